// File: rtl/axioma_pmu_ctrl.sv
// axioma_pmu_ctrl: CLKPR/WDTCSR/SMCR/MCUSR register block with timed-change windows and sleep/wake FSM
module axioma_pmu_ctrl #(
  parameter logic [7:0] ADDR_WDTCSR = 8'h60,
  parameter logic [7:0] ADDR_CLKPR = 8'h61,
  parameter logic [7:0] ADDR_SMCR = 8'h53,
  parameter logic [7:0] ADDR_MCUSR = 8'h54,
  parameter int WAKE_DELAY = 16
) (
  input logic clk,
  input logic reset,
  input logic [3:0] fuse_cksel,
  input logic fuse_ckdiv8,
  input logic [7:0] bus_addr,
  input logic bus_wr,
  input logic bus_rd,
  input logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  input logic wdr_exec,
  input logic sleep_exec,
  input logic wake_req,
  input logic [7:0] mcusr_in,
  output logic [3:0] clock_select,
  output logic [3:0] clock_prescaler,
  output logic wdt_enable,
  output logic [3:0] wdt_prescaler,
  output logic wdt_reset_req,
  output logic sleep_enable,
  output logic [2:0] sleep_mode,
  output logic [2:0] mcusr_clr,
  output logic cpu_halt,
  output logic cpu_wake,
  output logic [1:0] debug_state
);
  typedef enum logic [1:0] {AWAKE = 2'd0, SLEEP = 2'd1, WAKE = 2'd2} state_t;
  localparam int CW = WAKE_DELAY > 1 ? $clog2(WAKE_DELAY) : 1;
  state_t state, state_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic wake_n;
  logic [2:0] clk_win, wdt_win;
  logic [3:0] cksel, clkps;
  logic wde, wdie, wdp3, se;
  logic [2:0] wdp, sm;
  logic wr_clkpr, wr_wdt, wr_smcr, wr_mcusr, clk_open, wdt_open;
  logic [7:0] rd_data;
  assign wr_clkpr = bus_wr && bus_addr == ADDR_CLKPR;
  assign wr_wdt = bus_wr && bus_addr == ADDR_WDTCSR;
  assign wr_smcr = bus_wr && bus_addr == ADDR_SMCR;
  assign wr_mcusr = bus_wr && bus_addr == ADDR_MCUSR;
  assign clk_open = clk_win != 3'd0;
  assign wdt_open = wdt_win != 3'd0;
  assign rd_data = bus_addr == ADDR_CLKPR ? {clk_open, 3'b000, clkps} :
                   bus_addr == ADDR_WDTCSR ? {1'b0, wdie, wdp3, wdt_open, wde, wdp} :
                   bus_addr == ADDR_SMCR ? {4'b0000, sm, se} :
                   bus_addr == ADDR_MCUSR ? mcusr_in : 8'h00;
  assign clock_select = cksel;
  assign clock_prescaler = clkps;
  assign wdt_enable = wde;
  assign wdt_prescaler = {wdp3, wdp};
  assign sleep_mode = sm;
  assign sleep_enable = state != AWAKE;
  assign cpu_halt = state != AWAKE;
  assign debug_state = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      cksel <= fuse_cksel;
      clkps <= fuse_ckdiv8 ? 4'b0011 : 4'b0000;
      clk_win <= 3'd0;
      wdt_win <= 3'd0;
      wde <= mcusr_in[2];
      wdie <= 1'b0;
      wdp3 <= 1'b0;
      wdp <= 3'd0;
      sm <= 3'd0;
      se <= 1'b0;
      bus_rdata <= 8'h00;
      mcusr_clr <= 3'd0;
      wdt_reset_req <= 1'b0;
    end else begin
      clk_win <= clk_open ? clk_win - 3'd1 : 3'd0;
      if (wr_clkpr && bus_wdata == 8'h80) clk_win <= 3'd4;
      else if (wr_clkpr && !bus_wdata[7] && clk_open) begin
        clkps <= bus_wdata[3:0] > 4'b1000 ? 4'b1000 : bus_wdata[3:0];
        clk_win <= 3'd0;
      end
      wdt_win <= wdt_open ? wdt_win - 3'd1 : 3'd0;
      wde <= wde | mcusr_in[2];
      if (wr_wdt) begin
        if (bus_wdata[4] && bus_wdata[3]) begin
          wdt_win <= 3'd4;
          wde <= 1'b1;
          wdie <= bus_wdata[6];
        end else if (!bus_wdata[4] && wdt_open) begin
          wdt_win <= 3'd0;
          wde <= bus_wdata[3] | mcusr_in[2];
          wdie <= bus_wdata[6];
          wdp3 <= bus_wdata[5];
          wdp <= bus_wdata[2:0];
        end else begin
          wde <= wde | bus_wdata[3] | mcusr_in[2];
          wdie <= bus_wdata[6];
        end
      end
      if (wr_smcr) {sm, se} <= bus_wdata[3:0];
      mcusr_clr <= wr_mcusr ? ~bus_wdata[2:0] : 3'd0;
      wdt_reset_req <= wdr_exec;
      if (bus_rd) bus_rdata <= rd_data;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AWAKE;
      wcnt <= '0;
      cpu_wake <= 1'b0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      cpu_wake <= wake_n;
    end
  end
  always_comb begin
    state_n = state;
    wcnt_n = wcnt;
    wake_n = 1'b0;
    if (state == AWAKE && sleep_exec && se && sm[2:1] != 2'b10) state_n = SLEEP;
    else if (state == SLEEP && wake_req) begin
      if (sm[2:1] == 2'b00) begin
        state_n = AWAKE;
        wake_n = 1'b1;
      end else begin
        state_n = WAKE;
        wcnt_n = CW'(WAKE_DELAY - 1);
      end
    end else if (state == WAKE) begin
      if (wcnt == '0) begin
        state_n = AWAKE;
        wake_n = 1'b1;
      end else wcnt_n = wcnt - 1'b1;
    end
  end
endmodule
